hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/ecap5_dproc_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl_sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the decode/execute hazard controller.
// FLUSH_DEPTH counts the discarded cycles including the cycle the branch is seen.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH      = 2'd1,
    LOAD_STALL = 2'd2
  } hazard_state_t;

  localparam int unsigned FLUSH_DEPTH = 2;
  localparam int unsigned REM_W       = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned REG_W       = 5;

  typedef logic [REM_W-1:0] flush_rem_t;

  localparam flush_rem_t FLUSH_RELOAD = flush_rem_t'(FLUSH_DEPTH - 1);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller.
// master drives the pipeline status; slave is the controller itself.
interface hazard_ctrl_if;
  import ecap5_dproc_pkg::*;

  logic             branch_i;
  logic             advance_i;
  logic [REG_W-1:0] dec_rs1_addr_i;
  logic [REG_W-1:0] dec_rs2_addr_i;
  logic             dec_rs1_used_i;
  logic             dec_rs2_used_i;
  logic             ex_load_i;
  logic [REG_W-1:0] ex_reg_addr_i;
  logic             decode_discard_o;
  logic             execute_discard_o;
  logic             fetch_stall_o;
  logic             decode_stall_o;
  logic [CNT_W-1:0] flush_count_o;
  logic [CNT_W-1:0] stall_count_o;

  modport master (
    output branch_i, advance_i, dec_rs1_addr_i, dec_rs2_addr_i,
           dec_rs1_used_i, dec_rs2_used_i, ex_load_i, ex_reg_addr_i,
    input  decode_discard_o, execute_discard_o, fetch_stall_o, decode_stall_o,
           flush_count_o, stall_count_o
  );

  modport slave (
    input  branch_i, advance_i, dec_rs1_addr_i, dec_rs2_addr_i,
           dec_rs1_used_i, dec_rs2_used_i, ex_load_i, ex_reg_addr_i,
    output decode_discard_o, execute_discard_o, fetch_stall_o, decode_stall_o,
           flush_count_o, stall_count_o
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      cnt_q <= '0;
    else if (inc_i && (cnt_q != {WIDTH{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Branch flush / load-use stall controller between decode and execute.
// All transitions are qualified by advance_i so a frozen pipeline freezes the FSM too.
module hazard_ctrl
  import ecap5_dproc_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  hazard_state_t state_q, state_d;
  flush_rem_t    rem_q, rem_d;
  logic          flush_inc, stall_inc;
  logic          load_use, rs1_hit, rs2_hit;
  logic          idle_hazard;

  assign rs1_hit  = hz.dec_rs1_used_i && (hz.dec_rs1_addr_i == hz.ex_reg_addr_i);
  assign rs2_hit  = hz.dec_rs2_used_i && (hz.dec_rs2_addr_i == hz.ex_reg_addr_i);
  assign load_use = hz.ex_load_i && (hz.ex_reg_addr_i != '0) && (rs1_hit || rs2_hit);

  // A branch outranks the load-use bubble; reset masks everything but the branch discard.
  assign idle_hazard = rst_i && !hz.branch_i && (state_q == IDLE) && load_use;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    flush_inc = 1'b0;
    stall_inc = 1'b0;
    if (hz.advance_i) begin
      if (hz.branch_i) begin
        state_d   = FLUSH;
        rem_d     = FLUSH_RELOAD;
        flush_inc = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_use) begin
              state_d   = LOAD_STALL;
              stall_inc = 1'b1;
            end
          end
          FLUSH: begin
            if (rem_q == flush_rem_t'(1)) begin
              state_d = IDLE;
              rem_d   = '0;
            end else begin
              rem_d = flush_rem_t'(rem_q - 1'b1);
            end
          end
          LOAD_STALL: state_d = IDLE;
          default: begin
            state_d = IDLE;
            rem_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    hz.decode_discard_o  = hz.branch_i || (rst_i && (state_q == FLUSH));
    hz.execute_discard_o = hz.branch_i || (rst_i && (state_q == FLUSH)) || idle_hazard;
    hz.fetch_stall_o     = idle_hazard ||
                           (rst_i && !hz.branch_i && (state_q == LOAD_STALL));
    hz.decode_stall_o    = hz.fetch_stall_o;
  end

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .count_o (hz.flush_count_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .count_o (hz.stall_count_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl plus a narrow sat_counter to reach saturation quickly.
module tb_hazard_ctrl;
  import ecap5_dproc_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       sat_inc = 1'b0;
  logic [1:0] sat_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .hz    (hif)
  );

  sat_counter #(.WIDTH(2)) u_sat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (sat_inc),
    .count_o (sat_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic br, input logic adv, input logic ld, input logic [4:0] exa,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    hif.branch_i       = br;
    hif.advance_i      = adv;
    hif.ex_load_i      = ld;
    hif.ex_reg_addr_i  = exa;
    hif.dec_rs1_addr_i = rs1;
    hif.dec_rs1_used_i = u1;
    hif.dec_rs2_addr_i = rs2;
    hif.dec_rs2_used_i = u2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // outputs packed as {dd, ed, fs, ds}
  task automatic outs(input string tag, input logic [3:0] exp);
    chk(tag, {hif.decode_discard_o, hif.execute_discard_o, hif.fetch_stall_o, hif.decode_stall_o}, exp);
  endtask

  initial begin
    // reset: hazard inputs present but stalls masked; discards follow branch only
    drive(0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 1);
    outs("rst_hazard_masked", 4'b0000);
    chk("rst_flush_cnt", hif.flush_count_o, 0);
    chk("rst_stall_cnt", hif.stall_count_o, 0);
    drive(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("rst_branch_discard", 4'b1100);
    tick();
    chk("rst_flush_cnt_held", hif.flush_count_o, 0);
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    tick();
    rst_i = 1'b1;
    #1;
    outs("idle_quiet", 4'b0000);

    // single branch pulse with continuous advance -> two discard cycles
    drive(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("br_c0", 4'b1100);
    tick();
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("br_c1", 4'b1100);
    tick();
    outs("br_c2", 4'b0000);
    chk("br_flush_cnt", hif.flush_count_o, 1);

    // load-use on rs2 -> two stall cycles, one execute discard
    drive(0, 1, 1, 5'd5, 5'd3, 1, 5'd5, 1);
    outs("lu_c0", 4'b0111);
    tick();
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("lu_c1", 4'b0011);
    tick();
    outs("lu_c2", 4'b0000);
    chk("lu_stall_cnt", hif.stall_count_o, 1);

    // load into x0 never stalls
    drive(0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    outs("x0_no_stall", 4'b0000);
    tick();
    chk("x0_stall_cnt", hif.stall_count_o, 1);

    // matching rs1 that is not used -> no hazard
    drive(0, 1, 1, 5'd7, 5'd7, 0, 5'd2, 1);
    outs("rs1_unused", 4'b0000);
    // used rs1 with advance low: stall shows but nothing moves
    drive(0, 0, 1, 5'd7, 5'd7, 1, 5'd2, 0);
    outs("rs1_hold", 4'b0111);
    tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("rs1_hold_after", 4'b0000);
    chk("rs1_hold_cnt", hif.stall_count_o, 1);

    // hazard and branch together: branch wins
    drive(1, 1, 1, 5'd9, 5'd9, 1, 5'd0, 0);
    outs("pri_c0", 4'b1100);
    tick();
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("pri_c1", 4'b1100);
    chk("pri_stall_cnt", hif.stall_count_o, 1);
    chk("pri_flush_cnt", hif.flush_count_o, 2);
    tick();
    outs("pri_c2", 4'b0000);

    // flush frozen by advance low for four cycles
    drive(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    tick();
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 4; i++) begin
      outs("frz_hold", 4'b1100);
      tick();
    end
    chk("frz_flush_cnt", hif.flush_count_o, 3);
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("frz_release", 4'b1100);
    tick();
    outs("frz_exit", 4'b0000);

    // branch inside FLUSH restarts the sequence
    drive(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    tick();
    outs("rs_c1", 4'b1100);
    tick();
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("rs_c2", 4'b1100);
    chk("rs_flush_cnt", hif.flush_count_o, 5);
    tick();
    outs("rs_c3", 4'b0000);

    // non-advancing branch does not enter FLUSH
    drive(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("nb_c0", 4'b1100);
    tick();
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("nb_c1", 4'b0000);
    chk("nb_flush_cnt", hif.flush_count_o, 5);

    // branch during LOAD_STALL suppresses the stall
    drive(0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0);
    tick();
    drive(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("ls_branch", 4'b1100);
    drive(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("ls_hold", 4'b0011);
    chk("ls_stall_cnt", hif.stall_count_o, 2);

    // async reset mid-LOAD_STALL, checked away from any clock edge
    #2;
    rst_i = 1'b0;
    #1;
    outs("arst_outs", 4'b0000);
    chk("arst_flush_cnt", hif.flush_count_o, 0);
    chk("arst_stall_cnt", hif.stall_count_o, 0);
    tick();
    rst_i = 1'b1;
    drive(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    outs("arst_release", 4'b0000);
    tick();
    outs("arst_release2", 4'b0000);

    // narrow counter saturates instead of wrapping
    sat_inc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_cnt", 32'(sat_cnt), (i > 3) ? 32'd3 : 32'(i));
    end
    sat_inc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
